// File: rtl/icyrisc_pkg.sv
// Shared types and constants for the IcyRisc multi-cycle control unit:
// FSM states, RV32I opcodes, ALU operation codes and datapath mux encodings.
package icyrisc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALR_ADR = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        SRC1_PC     = 2'd0,
        SRC1_PC_OLD = 2'd1,
        SRC1_RS1    = 2'd2
    } src1_sel_t;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } src2_sel_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_MEM        = 2'd1,
        RES_ALU_RESULT = 2'd2,
        RES_IMM        = 2'd3
    } result_src_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on !zero; funct3 bits 0 and 2 flip the sense.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        return zero ^ funct3[0] ^ funct3[2];
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control/handshake bundle between the main_fsm controller (master) and the
// IcyRisc datapath plus memory port (slave).
interface main_fsm_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  result_src;
    logic [2:0]  imm_src;
    logic [1:0]  ALU_src1_sel;
    logic [1:0]  ALU_src2_sel;
    logic [3:0]  ALU_ctrl;
    logic        illegal;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, imm_src, ALU_src1_sel, ALU_src2_sel, ALU_ctrl, illegal
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               result_src, imm_src, ALU_src1_sel, ALU_src2_sel, ALU_ctrl, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode, funct3 and funct7[5].
// Covers OP, OP-IMM and the branch compare ops; everything else adds.
module alu_decoder
    import icyrisc_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output alu_ctrl_t  alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        if (opcode_i == OPC_OP || opcode_i == OPC_OP_IMM) begin
            case (funct3_i)
                3'b000:  alu_ctrl_o = (opcode_i == OPC_OP && funct7_5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctrl_o = ALU_SLL;
                3'b010:  alu_ctrl_o = ALU_SLT;
                3'b011:  alu_ctrl_o = ALU_SLTU;
                3'b100:  alu_ctrl_o = ALU_XOR;
                3'b101:  alu_ctrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctrl_o = ALU_OR;
                default: alu_ctrl_o = ALU_AND;
            endcase
        end else if (opcode_i == OPC_BRANCH) begin
            case (funct3_i[2:1])
                2'b10:   alu_ctrl_o = ALU_SLT;
                2'b11:   alu_ctrl_o = ALU_SLTU;
                default: alu_ctrl_o = ALU_SUB;
            endcase
        end
    end

endmodule

// File: rtl/main_fsm.sv
// IcyRisc RV32I multi-cycle control FSM: registered state, combinational outputs.
// Build option ICYRISC_ILLEGAL_TRAP_EN: unknown opcodes lock into TRAP instead of acting as NOP.
module main_fsm
    import icyrisc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    main_fsm_if.master bus
);

    state_t      state_q, state_d;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    alu_ctrl_t   alu_dec;

    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
    result_src_t result_src;
    imm_src_t    imm_src;
    src1_sel_t   src1_sel;
    src2_sel_t   src2_sel;
    alu_ctrl_t   alu_ctrl;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign funct7_5 = bus.instr[30];

    alu_decoder u_alu_decoder (
        .opcode_i   (opcode),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .alu_ctrl_o (alu_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALU_OUT;
        imm_src    = IMM_I;
        src1_sel   = SRC1_PC;
        src2_sel   = SRC2_RS2;
        alu_ctrl   = ALU_ADD;
        // Outputs stay at zero while reset is held, whatever the current state.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    result_src = RES_ALU_RESULT;
                    src2_sel   = SRC2_FOUR;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    src1_sel = SRC1_PC_OLD;
                    src2_sel = SRC2_IMM;
                    if (opcode == OPC_AUIPC)    imm_src = IMM_U;
                    else if (opcode == OPC_JAL) imm_src = IMM_J;
                    else                        imm_src = IMM_B;
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
                        OPC_OP:              state_d = S_EXEC_R;
                        OPC_OP_IMM:          state_d = S_EXEC_I;
                        OPC_BRANCH:          state_d = S_BRANCH;
                        OPC_JAL:             state_d = S_JAL;
                        OPC_JALR:            state_d = S_JALR_ADR;
                        OPC_LUI:             state_d = S_LUI;
                        OPC_AUIPC:           state_d = S_ALU_WB;
`ifdef ICYRISC_ILLEGAL_TRAP_EN
                        default:             state_d = S_TRAP;
`else
                        default:             state_d = S_FETCH;
`endif
                    endcase
                end
                S_MEM_ADR: begin
                    src1_sel = SRC1_RS1;
                    src2_sel = SRC2_IMM;
                    imm_src  = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                    state_d  = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (bus.mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (bus.mem_ready) state_d = S_FETCH;
                end
                S_EXEC_R: begin
                    src1_sel = SRC1_RS1;
                    alu_ctrl = alu_dec;
                    state_d  = S_ALU_WB;
                end
                S_EXEC_I: begin
                    src1_sel = SRC1_RS1;
                    src2_sel = SRC2_IMM;
                    alu_ctrl = alu_dec;
                    state_d  = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    src1_sel = SRC1_RS1;
                    alu_ctrl = alu_dec;
                    pc_write = branch_taken(funct3, bus.zero);
                    state_d  = S_FETCH;
                end
                S_JALR_ADR: begin
                    src1_sel = SRC1_RS1;
                    src2_sel = SRC2_IMM;
                    state_d  = S_JAL;
                end
                S_JAL: begin
                    // PC takes the target already in ALU_out while the ALU forms the link address.
                    pc_write = 1'b1;
                    src1_sel = SRC1_PC_OLD;
                    src2_sel = SRC2_FOUR;
                    state_d  = S_ALU_WB;
                end
                S_LUI: begin
                    reg_write  = 1'b1;
                    result_src = RES_IMM;
                    imm_src    = IMM_U;
                    state_d    = S_FETCH;
                end
`ifdef ICYRISC_ILLEGAL_TRAP_EN
                S_TRAP: begin
                    illegal = 1'b1;
                    state_d = S_TRAP;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.adr_src      = adr_src;
    assign bus.ir_write     = ir_write;
    assign bus.pc_write     = pc_write;
    assign bus.reg_write    = reg_write;
    assign bus.result_src   = result_src;
    assign bus.imm_src      = imm_src;
    assign bus.ALU_src1_sel = src1_sel;
    assign bus.ALU_src2_sel = src2_sel;
    assign bus.ALU_ctrl     = alu_ctrl;
    assign bus.illegal      = illegal;

endmodule
